// File: rtl/som_pkg.sv
// rtl/som_pkg.sv - shared types and constants for the SOM scan controller
package som_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        FETCH_T,
        WAIT_T,
        UPD,
        FETCH_C,
        WAIT_C,
        WRITE,
        DUMP,
        DONE
    } state_t;

    // bit 1 selects x ascending, bit 0 selects y ascending
    localparam logic [1:0] SCAN_FWD  = 2'd3;
    localparam logic [1:0] SCAN_YREV = 2'd2;
    localparam logic [1:0] SCAN_XREV = 2'd1;
    localparam logic [1:0] SCAN_REV  = 2'd0;

    localparam int DEF_IMG_XW   = 6;
    localparam int DEF_IMG_YW   = 6;
    localparam int DEF_CB_W     = 6;
    localparam int DEF_PIX_W    = 24;
    localparam int DEF_ADDR_W   = 18;
    localparam int DEF_INIT_CYC = 192;

endpackage

// File: rtl/som_scan_addr_gen.sv
// rtl/som_scan_addr_gen.sv - x/y pixel pointer with mode-dependent scan order
module som_scan_addr_gen
    import som_pkg::*;
#(
    parameter int IMG_XW = DEF_IMG_XW,
    parameter int IMG_YW = DEF_IMG_YW,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              reload,
    input  logic              advance,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] nxt_addr,
    output logic              last_pixel
);

    logic [IMG_XW-1:0] x, x_start, x_end, x_nxt;
    logic [IMG_YW-1:0] y, y_start, y_end, y_nxt;
    logic              row_end;

    assign x_start = mode[1] ? '0 : '1;
    assign y_start = mode[0] ? '0 : '1;
    assign x_end   = ~x_start;
    assign y_end   = ~y_start;

    always_comb begin
        row_end    = (x == x_end);
        last_pixel = row_end && (y == y_end);
        x_nxt      = x;
        y_nxt      = y;
        if (last_pixel) begin
            x_nxt = x_start;
            y_nxt = y_start;
        end else if (row_end) begin
            x_nxt = x_start;
            y_nxt = mode[0] ? y + 1'b1 : y - 1'b1;
        end else begin
            x_nxt = mode[1] ? x + 1'b1 : x - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (reload) begin
            x <= x_start;
            y <= y_start;
        end else if (advance) begin
            x <= x_nxt;
            y <= y_nxt;
        end
    end

    assign cur_addr = ADDR_W'({y, x});
    assign nxt_addr = ADDR_W'({y_nxt, x_nxt});

endmodule

// File: rtl/som_scan_ctrl.sv
// rtl/som_scan_ctrl.sv - SOM training/classify scan sequencer with codebook dump
module som_scan_ctrl
    import som_pkg::*;
#(
    parameter int IMG_XW   = DEF_IMG_XW,
    parameter int IMG_YW   = DEF_IMG_YW,
    parameter int CB_W     = DEF_CB_W,
    parameter int PIX_W    = DEF_PIX_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INIT_CYC = DEF_INIT_CYC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [3:0]                  epochs,
    input  logic [PIX_W*(1<<CB_W)-1:0]  weight,
    input  logic                        win_valid,
    input  logic [CB_W-1:0]             win_idx,
    output logic                        if_oe,
    output logic [ADDR_W-1:0]           if_a,
    output logic                        pic_we,
    output logic [ADDR_W-1:0]           pic_a,
    output logic [PIX_W-1:0]            pic_d,
    output logic                        w_we,
    output logic [ADDR_W-1:0]           w_a,
    output logic [PIX_W-1:0]            w_d,
    output logic                        init_flag,
    output logic                        train_req,
    output logic                        busy,
    output logic                        done
);

    localparam int N    = 1 << CB_W;
    localparam int IC_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(INIT_CYC - 1);

    state_t            state;
    logic [1:0]        mode_q;
    logic [3:0]        epochs_q, ep_cnt, ep_nxt, ep_target;
    logic [IC_W-1:0]   init_cnt;
    logic [CB_W-1:0]   dump_cnt, dump_nxt;
    logic [1:0]        gen_mode;
    logic              gen_reload, gen_advance, last_pixel, idle_like;
    logic [ADDR_W-1:0] cur_addr, nxt_addr;
    logic [PIX_W-1:0]  wt [N];

    for (genvar k = 0; k < N; k++) begin : g_wt
        assign wt[k] = weight[PIX_W*k +: PIX_W];
    end

    // the pointer reloads on the start edge, before mode_q holds the new mode
    assign idle_like   = (state == IDLE) || (state == DONE);
    assign gen_mode    = idle_like ? mode : mode_q;
    assign gen_reload  = idle_like && start;
    assign gen_advance = (state == UPD) || (state == WRITE);
    assign ep_nxt      = ep_cnt + 4'd1;
    assign ep_target   = (epochs_q == 4'd0) ? 4'd1 : epochs_q;
    assign dump_nxt    = dump_cnt + 1'b1;

    som_scan_addr_gen #(
        .IMG_XW (IMG_XW),
        .IMG_YW (IMG_YW),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .mode       (gen_mode),
        .reload     (gen_reload),
        .advance    (gen_advance),
        .cur_addr   (cur_addr),
        .nxt_addr   (nxt_addr),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= '0;
            epochs_q  <= '0;
            ep_cnt    <= '0;
            init_cnt  <= '0;
            dump_cnt  <= '0;
            if_oe     <= 1'b0;
            if_a      <= '0;
            pic_we    <= 1'b0;
            pic_a     <= '0;
            pic_d     <= '0;
            w_we      <= 1'b0;
            w_a       <= '0;
            w_d       <= '0;
            init_flag <= 1'b0;
            train_req <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= INIT;
                        mode_q    <= mode;
                        epochs_q  <= epochs;
                        ep_cnt    <= '0;
                        init_cnt  <= '0;
                        init_flag <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                INIT: begin
                    if (init_cnt == IC_LAST) begin
                        state     <= FETCH_T;
                        init_flag <= 1'b0;
                        if_oe     <= 1'b1;
                        if_a      <= cur_addr;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                FETCH_T: begin
                    if_oe <= 1'b0;
                    state <= WAIT_T;
                end
                WAIT_T: begin
                    if (win_valid) begin
                        state     <= UPD;
                        train_req <= 1'b1;
                    end
                end
                UPD: begin
                    // nxt_addr already wraps to the scan start after the last pixel
                    train_req <= 1'b0;
                    if_oe     <= 1'b1;
                    if_a      <= nxt_addr;
                    state     <= FETCH_T;
                    if (last_pixel) begin
                        ep_cnt <= ep_nxt;
                        if (ep_nxt == ep_target)
                            state <= FETCH_C;
                    end
                end
                FETCH_C: begin
                    if_oe <= 1'b0;
                    state <= WAIT_C;
                end
                WAIT_C: begin
                    if (win_valid) begin
                        state  <= WRITE;
                        pic_we <= 1'b1;
                        pic_a  <= cur_addr;
                        pic_d  <= wt[win_idx];
                    end
                end
                WRITE: begin
                    pic_we <= 1'b0;
                    if (last_pixel) begin
                        state    <= DUMP;
                        dump_cnt <= '0;
                        w_we     <= 1'b1;
                        w_a      <= '0;
                        w_d      <= wt[0];
                    end else begin
                        state <= FETCH_C;
                        if_oe <= 1'b1;
                        if_a  <= nxt_addr;
                    end
                end
                DUMP: begin
                    if (dump_cnt == '1) begin
                        state <= DONE;
                        w_we  <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        dump_cnt <= dump_nxt;
                        w_a      <= ADDR_W'(dump_nxt);
                        w_d      <= wt[dump_nxt];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
